lm07_spi_master: RTL and testbench
==================================

# lm07_spi_master

SPI master that reads one 16-bit temperature word from an LM07-family sensor and presents it to the display/debug logic as a raw word, a signed 0.0625 °C code and a signed integer °C value. It is the initiator for the sensor's read-only 3-wire interface. It drives CS and SCK, samples SIO, and sits between the sensor pins and the temperature display path. A single SYSCLK domain is used; SCK is a divided, registered copy of SYSCLK.

## Interface
- CLK_DIV, 2: SYSCLK cycles per SCK half-period (≥1).
- CS_SETUP, 2: SYSCLK cycles from CS falling to the first SCK low phase start (≥1).
- CS_HOLD, 2: SYSCLK cycles from the final SCK falling edge to CS rising (≥1).
- SYSCLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  level request; a transfer is launched only when START=1 in IDLE.
- SIO  in  1  serial data from the sensor, MSB first.
- CS  out  1  active-low chip select, registered.
- SCK  out  1  serial clock, idle low, registered.
- BUSY  out  1  high while a transfer is in progress.
- VALID  out  1  one-cycle pulse; RAW, TEMP and DEGC were updated on this edge.
- RAW  out  16  last complete word received.
- TEMP  out  13  signed RAW[15:3], 0.0625 °C/LSB.
- DEGC  out  9  signed RAW[15:7], integer °C (floor).
- STATUS  out  3  RAW[2:0].

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD.
  - IDLE→SETUP on START=1. CS←0, BUSY←1 on that edge.
  - SETUP lasts CS_SETUP cycles with SCK=0, then goes to SHIFT.
  - SHIFT runs 16 SCK periods. Each period is CLK_DIV cycles of SCK=0 followed by CLK_DIV cycles of SCK=1.
  - SHIFT→HOLD on the edge that drives the 16th SCK falling.
  - HOLD lasts CS_HOLD cycles with SCK=0, CS=0.
  - HOLD→IDLE: CS←1, BUSY←0, VALID←1, and RAW←shift register, all on the same edge.
- Sampling:
  - SIO is shifted into a 16-bit shift register (LSB insert, left shift) on the same SYSCLK edge that drives SCK 0→1.
  - The sensor changes SIO only after SCK falls, so the bit is stable at that edge.
  - The first sample is the MSB, which the sensor presents as soon as CS falls.
- RAW, TEMP, DEGC and STATUS change only on the VALID edge, so all four are always mutually consistent.
- Counters:
  - A phase counter 0..CLK_DIV-1 and a bit counter 0..15.
  - SETUP and HOLD reuse the phase counter, sized to max(CLK_DIV, CS_SETUP, CS_HOLD).
- START in SETUP, SHIFT or HOLD is ignored and is not queued.
- If START is held high, a new transfer starts on the edge after VALID, so CS stays high for exactly 1 cycle between transfers.
- RST (any state, including mid-transfer): state IDLE, CS=1, SCK=0, BUSY=0, VALID=0, RAW=0, TEMP=0, DEGC=0, STATUS=0, and shift register cleared. An aborted transfer never produces VALID.

## Timing
- Let edge k be the edge where START is seen in IDLE; CS falls at k.
- SCK rising for bit n (n=0 is the MSB) and its sample occur at edge k+CS_SETUP+CLK_DIV+2n·CLK_DIV.
- Final SCK falling occurs at edge k+CS_SETUP+32·CLK_DIV.
- CS rising, VALID=1 and BUSY=0 occur at edge k+CS_SETUP+32·CLK_DIV+CS_HOLD.
- Latency with default parameters:
  - 68 cycles from edge k to VALID.
  - CS is low for 68 cycles.
  - SCK period is 4 cycles (80 ns at a 20 ns SYSCLK).
- Minimum transaction period is CS_SETUP+32·CLK_DIV+CS_HOLD+1 cycles (69 with defaults).

## Test plan
- Reset: hold RST 3 cycles, START=0 -> CS=1, SCK=0, BUSY=0, VALID=0, RAW=0 on every edge; no SCK edges for 100 cycles.
- Single read: sensor model word 0x0B9F, one-cycle START -> exactly 16 SCK pulses, VALID at edge k+68, RAW=0x0B9F, TEMP=0x173 (371, 23.1875 °C), DEGC=23, STATUS=3'b111.
- Negative temperature: sensor word 0xF387 -> RAW=0xF387, TEMP=-400 (13'h1E70), DEGC=-25 (9'h1E7), STATUS=3'b111.
- START during BUSY: pulse START at k+10 and k+40 -> only one transfer, one VALID, CS low for exactly 68 cycles.
- Reset mid-transfer: assert RST at k+30 for 1 cycle -> CS=1 and SCK=0 on that edge, no VALID, RAW stays 0; a following START yields a correct 0x0B9F read.
- Back-to-back with CLK_DIV=1, START held high -> SCK period 2 cycles, VALID every 37 cycles, CS high exactly 1 cycle between transfers, RAW=0x0B9F each time.

Source files
------------

// File: rtl/lm07_spi_master.sv
// lm07_spi_master: reads one 16-bit word from an LM07-family temperature sensor
// over its read-only 3-wire interface (CS, SCK, SIO). The word is presented raw,
// as a 0.0625 C signed code, as a signed integer degree C value, and as status bits.
module lm07_spi_master #(
  parameter int CLK_DIV  = 2,  // SYSCLK cycles per SCK half-period
  parameter int CS_SETUP = 2,  // CS fall to start of first SCK low phase
  parameter int CS_HOLD  = 2   // last SCK fall to CS rise
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        sio_i,
  output logic        cs_o,
  output logic        sck_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [15:0] raw_o,
  output logic [12:0] temp_o,
  output logic [8:0]  degc_o,
  output logic [2:0]  status_o
);

  // One phase counter serves SETUP, SHIFT and HOLD, so it is sized for the longest.
  localparam int PMAX0 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int PMAX  = (PMAX0 > CS_HOLD) ? PMAX0 : CS_HOLD;
  localparam int PW    = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [PW-1:0] DIV_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(CS_SETUP - 1);
  localparam logic [PW-1:0] HOLD_LAST  = PW'(CS_HOLD - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ph_q, ph_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     sr_q, sr_d;
  logic [15:0]     raw_q, raw_d;
  logic            cs_q, cs_d;
  logic            sck_q, sck_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  // State and datapath registers; reset aborts any transfer without a VALID.
  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      raw_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      raw_q   <= raw_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: CS setup, 16 SCK periods sampling on each rising edge, CS hold.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    raw_d   = raw_q;
    cs_d    = cs_q;
    sck_d   = sck_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          sck_d   = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
        end
      end
      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          state_d = SHIFT;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      SHIFT: begin
        if (ph_q == DIV_LAST) begin
          ph_d = '0;
          if (!sck_q) begin
            // Rising SCK: the sensor has held SIO stable since the previous fall.
            sck_d = 1'b1;
            sr_d  = {sr_q[14:0], sio_i};
          end else begin
            sck_d = 1'b0;
            if (bit_q == 4'd15) state_d = HOLD;
            else                bit_d   = bit_q + 4'd1;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          raw_d   = sr_q;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cs_o     = cs_q;
  assign sck_o    = sck_q;
  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign raw_o    = raw_q;
  // All decoded views come from the one RAW register, so they always agree.
  assign temp_o   = raw_q[15:3];
  assign degc_o   = raw_q[15:7];
  assign status_o = raw_q[2:0];

endmodule

// File: tb/tb_lm07_spi_master.sv
// Directed bench for lm07_spi_master: default-parameter instance for single reads,
// ignored START, mid-transfer reset; CLK_DIV=1 instance for back-to-back reads.
module tb_lm07_spi_master;

  logic        clk = 1'b0;
  logic        rst, start, start1;
  logic        sio, sio1;
  logic        cs, sck, busy, valid;
  logic        cs1, sck1, busy1, valid1;
  logic [15:0] raw, raw1;
  logic [12:0] temp, temp1;
  logic [8:0]  degc, degc1;
  logic [2:0]  status, status1;
  logic [15:0] word = 16'h0B9F;
  logic [15:0] word1 = 16'h0B9F;
  int          idx = 0, idx1 = 0;
  int          ncmp = 0, nerr = 0;

  always #10 clk = ~clk;

  lm07_spi_master dut (
    .sysclk_i(clk), .rst_i(rst), .start_i(start), .sio_i(sio),
    .cs_o(cs), .sck_o(sck), .busy_o(busy), .valid_o(valid),
    .raw_o(raw), .temp_o(temp), .degc_o(degc), .status_o(status)
  );

  lm07_spi_master #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) dut1 (
    .sysclk_i(clk), .rst_i(rst), .start_i(start1), .sio_i(sio1),
    .cs_o(cs1), .sck_o(sck1), .busy_o(busy1), .valid_o(valid1),
    .raw_o(raw1), .temp_o(temp1), .degc_o(degc1), .status_o(status1)
  );

  // Sensor models: MSB out when CS falls, next bit after each SCK fall.
  always @(negedge sck or posedge cs) begin
    if (cs === 1'b1) idx = 0;
    else             idx = idx + 1;
  end
  assign sio = (cs === 1'b0 && idx < 16) ? word[15 - idx] : 1'b0;

  always @(negedge sck1 or posedge cs1) begin
    if (cs1 === 1'b1) idx1 = 0;
    else              idx1 = idx1 + 1;
  end
  assign sio1 = (cs1 === 1'b0 && idx1 < 16) ? word1[15 - idx1] : 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // START seen at edge k; leaves the bench 1 time unit after edge k.
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("launch_cs", {31'b0, cs}, 32'd0);
    chk("launch_busy", {31'b0, busy}, 32'd1);
  endtask

  // Runs from edge k until VALID or budget; optional START pulses and a reset pulse
  // seen at edge k+pa, k+pb, k+ra. Counts CS-low samples (including edge k) and SCK rises.
  task automatic run(input int pa, input int pb, input int ra, input int budget,
                     output int n, output int lowc, output int pulses, output bit gotv);
    logic prev;
    gotv = 1'b0; lowc = 1; pulses = 0; n = 0; prev = sck;
    while (!gotv && n < budget) begin
      start = (n + 1 == pa) || (n + 1 == pb);
      rst   = (n + 1 == ra);
      @(posedge clk);
      #1;
      n++;
      if (sck && !prev) pulses++;
      prev = sck;
      if (!cs) lowc++;
      if (valid) gotv = 1'b1;
      if (n == ra) begin
        chk("midrst_cs", {31'b0, cs}, 32'd1);
        chk("midrst_sck", {31'b0, sck}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [15:0] r, input logic [12:0] t,
                            input logic [8:0] d, input logic [2:0] s);
    chk({tag, "_raw"}, {16'b0, raw}, {16'b0, r});
    chk({tag, "_temp"}, {19'b0, temp}, {19'b0, t});
    chk({tag, "_degc"}, {23'b0, degc}, {23'b0, d});
    chk({tag, "_status"}, {29'b0, status}, {29'b0, s});
  endtask

  initial begin
    int  n, lowc, pul, cnt, lows, hi, nv, tlast, t;
    bit  gv;
    logic prev;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_cs", {31'b0, cs}, 32'd1);
      chk("rst_sck", {31'b0, sck}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_valid", {31'b0, valid}, 32'd0);
      chk("rst_raw", {16'b0, raw}, 32'd0);
    end
    rst = 1'b0;

    // Idle: no SCK activity, CS stays high
    cnt = 0; lows = 0; prev = sck;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (sck && !prev) cnt++;
      prev = sck;
      if (!cs) lows++;
    end
    chk("idle_sck_edges", cnt, 0);
    chk("idle_cs_low", lows, 0);

    // Single read of 0x0B9F
    word = 16'h0B9F;
    launch();
    run(-1, -1, -1, 200, n, lowc, pul, gv);
    chk("read1_valid", {31'b0, gv}, 32'd1);
    chk("read1_latency", n, 68);
    chk("read1_cs_low", lowc, 68);
    chk("read1_sck_pulses", pul, 16);
    chk("read1_cs_at_valid", {31'b0, cs}, 32'd1);
    chk("read1_busy_at_valid", {31'b0, busy}, 32'd0);
    check_word("read1", 16'h0B9F, 13'h173, 9'd23, 3'b111);
    @(posedge clk);
    #1;
    chk("read1_valid_pulse", {31'b0, valid}, 32'd0);

    // Negative temperature 0xF387
    word = 16'hF387;
    repeat (3) @(posedge clk);
    launch();
    run(-1, -1, -1, 200, n, lowc, pul, gv);
    chk("neg_valid", {31'b0, gv}, 32'd1);
    chk("neg_latency", n, 68);
    check_word("neg", 16'hF387, 13'h1E70, 9'h1E7, 3'b111);

    // START pulses at k+10 and k+40 are ignored
    word = 16'h0B9F;
    repeat (3) @(posedge clk);
    launch();
    run(10, 40, -1, 200, n, lowc, pul, gv);
    chk("busy_start_valid", {31'b0, gv}, 32'd1);
    chk("busy_start_latency", n, 68);
    chk("busy_start_cs_low", lowc, 68);
    check_word("busy_start", 16'h0B9F, 13'h173, 9'd23, 3'b111);
    cnt = 0; lows = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid) cnt++;
      if (!cs) lows++;
    end
    chk("busy_start_extra_valid", cnt, 0);
    chk("busy_start_extra_cs_low", lows, 0);

    // Reset at k+30 aborts the transfer; no VALID, RAW cleared
    word = 16'hF387;
    launch();
    run(-1, -1, 30, 100, n, lowc, pul, gv);
    chk("midrst_no_valid", {31'b0, gv}, 32'd0);
    chk("midrst_raw", {16'b0, raw}, 32'd0);
    chk("midrst_cs_after", {31'b0, cs}, 32'd1);
    word = 16'h0B9F;
    launch();
    run(-1, -1, -1, 200, n, lowc, pul, gv);
    chk("after_rst_valid", {31'b0, gv}, 32'd1);
    chk("after_rst_latency", n, 68);
    check_word("after_rst", 16'h0B9F, 13'h173, 9'd23, 3'b111);

    // Back-to-back, CLK_DIV=1, START held high
    @(negedge clk);
    start1 = 1'b1;
    nv = 0; hi = 0; tlast = 0; t = 0; pul = 0; prev = sck1;
    while (nv < 3 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
      if (sck1 && !prev) pul++;
      prev = sck1;
      if (cs1) hi++;
      else begin
        if (nv > 0 && hi > 0) chk("b2b_cs_high", hi, 1);
        hi = 0;
      end
      if (valid1) begin
        nv++;
        chk("b2b_raw", {16'b0, raw1}, 32'h0B9F);
        chk("b2b_sck_pulses", pul, 16);
        if (nv == 1) chk("b2b_first_latency", t, 37);
        else         chk("b2b_period", t - tlast, 37);
        tlast = t;
        pul = 0;
      end
    end
    chk("b2b_valid_count", nv, 3);
    start1 = 1'b0;
    repeat (50) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
